// File: rtl/divide.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Flush-to-zero on denormals, truncating rounding, NaN/Inf inputs report overflow rather than propagating.
module divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        div_done,
    output logic        div_overflow,
    output logic        div_by_zero,
    output logic [31:0] div_result
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [24:0]        rem_q, rem_d;
    logic [23:0]        dvs_q, dvs_d;
    logic [24:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;
    logic [31:0]        result_q, result_d;

    logic [7:0]         exp1, exp2;
    logic               sign_in;
    logic [24:0]        rem_diff;
    logic signed [9:0]  exp_norm;
    logic [22:0]        frac_norm;

    assign exp1     = op1[30:23];
    assign exp2     = op2[30:23];
    assign sign_in  = op1[31] ^ op2[31];
    assign rem_diff = rem_q - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        result_d  = result_q;
        exp_norm  = exp_q;
        frac_norm = quo_q[23:1];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (div_start) begin
                    sign_d = sign_in;
                    done_d = 1'b0;
                    ovf_d  = 1'b0;
                    dbz_d  = 1'b0;
                    // Special cases resolve on the accepting edge, in priority order.
                    if (exp2 == 8'h00) begin
                        result_d = {sign_in, 8'hFF, 23'h0};
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (exp1 == 8'h00) begin
                        result_d = {sign_in, 31'h0};
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (exp1 == 8'hFF || exp2 == 8'hFF) begin
                        result_d = {sign_in, 8'hFF, 23'h0};
                        ovf_d    = 1'b1;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        exp_d   = $signed({2'b00, exp1}) - $signed({2'b00, exp2}) + 10'sd127;
                        rem_d   = {2'b01, op1[22:0]};
                        dvs_d   = {1'b1, op2[22:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_DIVIDE;
                    end
                end
            end

            ST_DIVIDE: begin
                if (rem_q >= {1'b0, dvs_q}) begin
                    quo_d = {quo_q[23:0], 1'b1};
                    rem_d = {rem_diff[23:0], 1'b0};
                end else begin
                    quo_d = {quo_q[23:0], 1'b0};
                    rem_d = {rem_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
                if (quo_q[24]) begin
                    frac_norm = quo_q[23:1];
                    exp_norm  = exp_q;
                end else begin
                    frac_norm = quo_q[22:0];
                    exp_norm  = exp_q - 10'sd1;
                end
                if (exp_norm >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d    = 1'b1;
                end else if (exp_norm <= 10'sd0) begin
                    result_d = {sign_q, 31'h0};
                end else begin
                    result_d = {sign_q, exp_norm[7:0], frac_norm};
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign div_done     = done_q;
    assign div_overflow = ovf_q;
    assign div_by_zero  = dbz_q;
    assign div_result   = result_q;

endmodule

// File: tb/tb_divide.sv
// Directed-vector bench for the sequential FP divider: values, flags and done latency.
module tb_divide;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        div_done;
    logic        div_overflow;
    logic        div_by_zero;
    logic [31:0] div_result;

    int errors = 0;
    int checks = 0;

    divide dut (
        .clk          (clk),
        .rst          (rst),
        .div_start    (div_start),
        .op1          (op1),
        .op2          (op2),
        .div_done     (div_done),
        .div_overflow (div_overflow),
        .div_by_zero  (div_by_zero),
        .div_result   (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count edges after the accepting one until done.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!div_done && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ovf, input logic exp_dbz,
                         input int exp_lat);
        int lat;
        op1       = a;
        op2       = b;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        op1       = 32'hDEAD_BEEF;
        op2       = 32'h1234_5678;
        if (exp_lat > 0) begin
            check({tag, "_busy"}, {31'h0, div_done}, 32'h0);
        end
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, div_result, exp_res);
        check({tag, "_ovf"}, {31'h0, div_overflow}, {31'h0, exp_ovf});
        check({tag, "_dbz"}, {31'h0, div_by_zero}, {31'h0, exp_dbz});
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        div_start = 1'b1;
        op1       = 32'h4040_0000;
        op2       = 32'h3FC0_0000;
        tick();
        tick();
        check("rst_done", {31'h0, div_done}, 32'h0);
        check("rst_res",  div_result, 32'h0);
        check("rst_ovf",  {31'h0, div_overflow}, 32'h0);
        check("rst_dbz",  {31'h0, div_by_zero}, 32'h0);
        div_start = 1'b0;
        rst       = 1'b0;
        tick();
        check("idle_done", {31'h0, div_done}, 32'h0);

        // Normal path: latency 26 edges after acceptance; later ops issued from DONE.
        do_op("pos",   32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 1'b0, 1'b0, 26);
        do_op("neg",   32'h40C0_0000, 32'hC000_0000, 32'hC040_0000, 1'b0, 1'b0, 26);
        do_op("third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 26);

        // Special cases resolve on the accepting edge.
        do_op("dbz",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 0);
        do_op("zero",  32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 0);
        do_op("zz",    32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 0);
        do_op("inf",   32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1, 1'b0, 0);
        do_op("nsgn",  32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1, 0);

        // Exponent range limits after normalization.
        do_op("ovf",   32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 26);
        do_op("unf",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 26);

        // Start during DIVIDE must be ignored.
        op1       = 32'h4040_0000;
        op2       = 32'h3FC0_0000;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        repeat (5) tick();
        op1       = 32'h3F80_0000;
        op2       = 32'h4040_0000;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        wait_done(lat);
        check("busy_lat", lat + 6, 26);
        check("busy_res", div_result, 32'h4000_0000);

        // Reset at DIVIDE cycle 10 abandons the operation.
        op1       = 32'h40C0_0000;
        op2       = 32'hC000_0000;
        div_start = 1'b1;
        tick();
        div_start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_done", {31'h0, div_done}, 32'h0);
        check("mrst_res",  div_result, 32'h0);
        check("mrst_ovf",  {31'h0, div_overflow}, 32'h0);
        check("mrst_dbz",  {31'h0, div_by_zero}, 32'h0);
        tick();
        check("mrst_idle", {31'h0, div_done}, 32'h0);
        do_op("post",  32'h40C0_0000, 32'hC000_0000, 32'hC040_0000, 1'b0, 1'b0, 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
